// File: rtl/niu_sii_inb_checker.sv
// Passive checker and traffic tracker for the NIU->SII inbound DMA request bus.
// Define NIU_SII_INB_PAR_CHK_EN to build per-group even data parity checking (err_code 3).
module niu_sii_inb_checker #(
  parameter  int DATA_W   = 128,
  parameter  int PAR_GRP  = 16,
  parameter  int WR_BEATS = 4,
  parameter  int OQ_DEPTH = 16,
  parameter  int CNT_W    = 16,
  localparam int PAR_W    = DATA_W / PAR_GRP,
  localparam int OQ_W     = $clog2(OQ_DEPTH + 1)
) (
  input  logic              iol2clk,
  input  logic              rst_l,
  input  logic              chk_en,
  input  logic              niu_sii_hdr_vld,
  input  logic              niu_sii_reqbypass,
  input  logic              niu_sii_datareq,
  input  logic              niu_sii_datareq16,
  input  logic [DATA_W-1:0] niu_sii_data,
  input  logic [PAR_W-1:0]  niu_sii_parity,
  input  logic              sii_niu_oqdq,
  output logic [CNT_W-1:0]  rd_cnt,
  output logic [CNT_W-1:0]  wr_cnt,
  output logic [OQ_W-1:0]   oq_cnt,
  output logic              busy,
  output logic              err_vld,
  output logic [2:0]        err_code,
  output logic [4:0]        err_sts
);

  localparam int BC_W = $clog2(WR_BEATS + 1);

  typedef enum logic {S_IDLE = 1'b0, S_PAYLOAD = 1'b1} state_t;

  state_t           r_state;
  logic [BC_W-1:0]  r_beat_cnt;
  logic [CNT_W-1:0] r_rd_cnt;
  logic [CNT_W-1:0] r_wr_cnt;
  logic [OQ_W-1:0]  r_oq_cnt;
  logic             r_err_vld;
  logic [2:0]       r_err_code;
  logic [4:0]       r_err_sts;

  logic       w_in_payload;
  logic       w_hdr_idle;
  logic       w_illegal;
  logic       w_accept;
  logic       w_is_rd;
  logic       w_is_wr;
  logic       w_hdr_in_pay;
  logic       w_par_err;
  logic       w_inc;
  logic       w_dec;
  logic       w_ovf;
  logic       w_udf;
  logic [4:0] w_err_vec;
  logic [2:0] w_err_code;

  assign w_in_payload = (r_state == S_PAYLOAD);
  assign w_hdr_idle   = niu_sii_hdr_vld && !w_in_payload;
  assign w_illegal    = w_hdr_idle && !niu_sii_datareq && niu_sii_datareq16;
  assign w_accept     = w_hdr_idle && !w_illegal;
  assign w_is_rd      = w_accept && !niu_sii_datareq;
  assign w_is_wr      = w_accept && niu_sii_datareq;
  assign w_hdr_in_pay = niu_sii_hdr_vld && w_in_payload;

`ifdef NIU_SII_INB_PAR_CHK_EN
  logic [PAR_W-1:0] w_par_calc;
  for (genvar gi = 0; gi < PAR_W; gi++) begin : g_par
    assign w_par_calc[gi] = ^niu_sii_data[gi*PAR_GRP +: PAR_GRP];
  end
  assign w_par_err = (w_hdr_idle || w_in_payload) && (w_par_calc != niu_sii_parity);
`else
  logic w_unused_par;
  assign w_unused_par = &{1'b0, niu_sii_data, niu_sii_parity};
  assign w_par_err    = 1'b0;
`endif

  // Simultaneous enqueue and dequeue cancel, so neither boundary error can fire then.
  assign w_inc = w_accept && !niu_sii_reqbypass;
  assign w_dec = sii_niu_oqdq;
  assign w_ovf = w_inc && !w_dec && (r_oq_cnt == OQ_W'(OQ_DEPTH));
  assign w_udf = w_dec && !w_inc && (r_oq_cnt == '0);

  assign w_err_vec = {w_udf, w_ovf, w_par_err, w_hdr_in_pay, w_illegal};

  always_comb begin
    w_err_code = 3'd0;
    for (int i = 4; i >= 0; i--) begin
      if (w_err_vec[i]) w_err_code = 3'(i + 1);
    end
  end

  always_ff @(posedge iol2clk) begin
    if (!rst_l) begin
      r_state    <= S_IDLE;
      r_beat_cnt <= '0;
      r_rd_cnt   <= '0;
      r_wr_cnt   <= '0;
      r_oq_cnt   <= '0;
      r_err_vld  <= 1'b0;
      r_err_code <= 3'd0;
      r_err_sts  <= 5'd0;
    end else if (!chk_en) begin
      r_err_vld <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_is_wr) begin
            r_state    <= S_PAYLOAD;
            r_beat_cnt <= niu_sii_datareq16 ? BC_W'(1) : BC_W'(WR_BEATS);
          end
        end
        S_PAYLOAD: begin
          r_beat_cnt <= r_beat_cnt - 1'b1;
          if (r_beat_cnt == BC_W'(1)) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_is_rd && (r_rd_cnt != '1)) r_rd_cnt <= r_rd_cnt + 1'b1;
      if (w_is_wr && (r_wr_cnt != '1)) r_wr_cnt <= r_wr_cnt + 1'b1;

      if (w_inc && !w_dec && !w_ovf)      r_oq_cnt <= r_oq_cnt + 1'b1;
      else if (w_dec && !w_inc && !w_udf) r_oq_cnt <= r_oq_cnt - 1'b1;

      r_err_vld  <= |w_err_vec;
      r_err_code <= w_err_code;
      r_err_sts  <= r_err_sts | w_err_vec;
    end
  end

  assign rd_cnt   = r_rd_cnt;
  assign wr_cnt   = r_wr_cnt;
  assign oq_cnt   = r_oq_cnt;
  assign busy     = w_in_payload;
  assign err_vld  = r_err_vld;
  assign err_code = r_err_code;
  assign err_sts  = r_err_sts;

endmodule
